// File: rtl/pq_pkg.sv
// pq_pkg: shared widths, key/value pair type and adapter state encoding.
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  localparam int KV_WIDTH = KEY_WIDTH + VAL_WIDTH;
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;
  typedef enum logic {RUN, FLUSH} adapter_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy level; head reads as zero when empty.
module sync_fifo #(
  parameter int W = 16,
  parameter int D = 4,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  assign full = level == (AW+1)'(D);
  assign empty = level == '0;
  assign dout = empty ? '0 : mem[rd];
endmodule

// File: rtl/pq_stream_adapter.sv
// pq_stream_adapter: valid/ready front end around the shift-register priority queue.
// Enqueues from an input FIFO, dequeues into a one-entry output register, supports full drain.
module pq_stream_adapter #(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]  in_kv,
  input  logic                            flush,
  output logic                            flush_done,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]  pq_kvi,
  output logic                            pq_enq,
  output logic                            pq_deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]  pq_kvo,
  input  logic                            pq_full,
  input  logic                            pq_empty,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]  out_kv,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  import pq_pkg::*;
  localparam int KV = KEY_WIDTH + VAL_WIDTH;
  adapter_state_t state, state_d;
  logic fifo_full, fifo_empty, out_free, run;
  assign run = state == RUN;
  assign in_ready = run & !fifo_full;
  assign out_free = !out_valid | out_ready;
  // Enqueue wins; dequeue waits for the FIFO to empty so bursts get sorted first.
  always_comb begin
    pq_enq = rst_n & run & !fifo_empty & !pq_full;
    pq_deq = rst_n & !pq_enq & !pq_empty & out_free & (!run | fifo_empty | pq_full);
    flush_done = !run & pq_empty;
    state_d = run ? (flush ? FLUSH : RUN) : (flush_done ? RUN : FLUSH);
  end
  sync_fifo #(.W(KV), .D(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid & in_ready),
    .pop   (pq_enq),
    .din   (in_kv),
    .dout  (pq_kvi),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      out_valid <= 1'b0;
      out_kv <= '0;
    end else begin
      state <= state_d;
      if (pq_deq) begin
        out_valid <= 1'b1;
        out_kv <= pq_kvo;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pq_stream_adapter.sv
// tb_pq_stream_adapter: transaction-level model of adapter and PQ, compared every cycle.
module tb_pq_stream_adapter;
  import pq_pkg::*;
  localparam int DEPTH = 4;
  localparam int CAP = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic pq_full = 0, pq_empty = 1;
  logic in_ready, flush_done, pq_enq, pq_deq, out_valid;
  logic [KV_WIDTH-1:0] in_kv = '0, pq_kvo = '0, pq_kvi, out_kv;
  logic [LW-1:0] fifo_level;
  int n_cmp = 0, n_err = 0, n_acc = 0, n_del = 0, n_fd = 0;
  bit seen_full = 0;
  kv_t fq[$], pq[$], m_okv;
  bit m_flush, m_ov;

  always #5 clk = ~clk;

  pq_stream_adapter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv),
    .flush(flush), .flush_done(flush_done), .pq_kvi(pq_kvi), .pq_enq(pq_enq), .pq_deq(pq_deq),
    .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_kv(out_kv), .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pq_insert(input kv_t x);
    int i = 0;
    while (i < pq.size() && pq[i].key <= x.key) i++;
    pq.insert(i, x);
  endtask

  task automatic drive_pq();
    pq_empty = pq.size() == 0;
    pq_full = pq.size() == CAP;
    pq_kvo = pq.size() != 0 ? pq[0] : '0;
  endtask

  task automatic model_reset();
    fq.delete();
    m_flush = 0;
    m_ov = 0;
    m_okv = '0;
  endtask

  task automatic step();
    bit run, fne, pe, pf, ofree, e_enq, e_deq, e_ir, e_done;
    kv_t e_kvi, hd;
    #1;
    run = !m_flush;
    fne = fq.size() != 0;
    pe = pq.size() == 0;
    pf = pq.size() == CAP;
    ofree = !m_ov || out_ready;
    e_enq = rst_n && run && fne && !pf;
    e_deq = rst_n && !e_enq && !pe && ofree && (!run || !fne || pf);
    e_ir = run && fq.size() < DEPTH;
    e_done = !run && pe;
    e_kvi = fne ? fq[0] : '0;
    hd = pe ? '0 : pq[0];
    chk("pq_enq", 32'(pq_enq), 32'(e_enq));
    chk("pq_deq", 32'(pq_deq), 32'(e_deq));
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("flush_done", 32'(flush_done), 32'(e_done));
    chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
    chk("pq_kvi", 32'(pq_kvi), 32'(e_kvi));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_kv", 32'(out_kv), 32'(m_okv));
    if (fq.size() == DEPTH) seen_full = 1;
    if (rst_n && out_valid && out_ready) n_del++;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e_enq) pq_insert(fq.pop_front());
      if (in_valid && e_ir) begin
        fq.push_back(in_kv);
        n_acc++;
      end
      if (e_deq) begin
        void'(pq.pop_front());
        m_ov = 1;
        m_okv = hd;
      end else if (out_ready) m_ov = 0;
      if (run && flush) m_flush = 1;
      else if (e_done) m_flush = 0;
    end
    drive_pq();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    drive_pq();
    @(negedge clk);
    step();
    step();
    rst_n = 1;
    step();
    // single pair, no backpressure
    out_ready = 1;
    in_valid = 1;
    in_kv = {8'd8, 8'd14};
    step();
    in_valid = 0;
    repeat (5) step();
    // sorted burst held behind a stalled output
    out_ready = 0;
    in_valid = 1;
    in_kv = {8'd9, 8'd10}; step();
    in_kv = {8'd9, 8'd11}; step();
    in_kv = {8'd9, 8'd12}; step();
    in_kv = {8'd1, 8'd11}; step();
    in_valid = 0;
    repeat (6) step();
    chk("burst_first_key", 32'(out_kv[15:8]), 32'd1);
    out_ready = 1;
    repeat (8) step();
    // six pairs into a capacity-4 PQ, free-running output
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_kv = {8'($urandom_range(0, 15)), 8'(i)};
      step();
    end
    in_valid = 0;
    repeat (12) step();
    // overfill with output stalled so the FIFO saturates
    out_ready = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1;
      in_kv = {8'($urandom_range(0, 15)), 8'($urandom)};
      step();
    end
    in_valid = 0;
    chk("fifo_full_seen", 32'(seen_full), 32'd1);
    out_ready = 1;
    repeat (20) step();
    // flush with three pairs queued
    out_ready = 0;
    in_valid = 1;
    in_kv = {8'd7, 8'd1}; step();
    in_kv = {8'd3, 8'd2}; step();
    in_kv = {8'd5, 8'd3}; step();
    in_valid = 0;
    repeat (4) step();
    out_ready = 1;
    flush = 1;
    step();
    flush = 0;
    n_fd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (flush_done) n_fd++;
    end
    chk("flush_done_pulses", 32'(n_fd), 32'd1);
    // reset in the middle of a burst
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_kv = {8'($urandom_range(0, 15)), 8'($urandom)};
      step();
    end
    #2;
    rst_n = 0;
    model_reset();
    n_acc = pq.size();
    n_del = 0;
    in_valid = 0;
    out_ready = 1;
    step();
    step();
    rst_n = 1;
    step();
    // random traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_kv = {8'($urandom_range(0, 15)), 8'($urandom)};
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    repeat (40) step();
    chk("conservation", 32'(n_del), 32'(n_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
